// File: rtl/seq_detect_1011.sv
// Overlapping serial "1011" detector with a registered detect pulse and a
// saturating match counter; FSM state is exported for debug.
module seq_detect_1011 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clear,
   output logic             detect,
   output logic [CNT_W-1:0] count,
   output logic [2:0]       state
);

   // bit_valid is a qualifier, not a handshake: bit_in is consumed on every
   // rising edge where bit_valid=1 and ignored otherwise; there is no ready.
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             detect_q, detect_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S0;
         detect_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         detect_q <= detect_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      detect_d = 1'b0;
      count_d  = count_q;
      if (clear) begin
         state_d = S0;
         count_d = '0;
      end else begin
         case (state_q)
            S0: if (bit_valid) state_d = bit_in ? S1 : S0;
            S1: if (bit_valid) state_d = bit_in ? S1 : S2;
            S2: if (bit_valid) state_d = bit_in ? S3 : S0;
            S3: begin
               if (bit_valid) begin
                  state_d = bit_in ? S4 : S2;
                  if (bit_in) begin
                     detect_d = 1'b1;
                     if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
                  end
               end
            end
            S4: if (bit_valid) state_d = bit_in ? S1 : S2;
            // Codes 5-7 recover on the next edge whether or not a bit is valid.
            default: state_d = S0;
         endcase
      end
   end

   assign detect = detect_q;
   assign count  = count_q;
   assign state  = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Randomized and directed bench for seq_detect_1011: two instances (CNT_W=8 and
// CNT_W=2) share one stimulus stream and are checked against a suffix model.
module tb_seq_detect_1011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_in;
   logic       bit_valid;
   logic       clear;
   logic       detect_a, detect_b;
   logic [7:0] count_a;
   logic [1:0] count_b;
   logic [2:0] state_a, state_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: last accepted bits, total matches, last detect.
   bit hist[$];
   int m_matches;
   bit m_detect;
   bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   seq_detect_1011 #(.CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .clear(clear), .detect(detect_a), .count(count_a), .state(state_a)
   );

   seq_detect_1011 #(.CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .clear(clear), .detect(detect_b), .count(count_b), .state(state_b)
   );

   always #5 clk = ~clk;

   // Longest suffix of the accepted history that is a prefix of 1011.
   function automatic int exp_state();
      int n;
      bit ok;
      n = hist.size();
      for (int k = 4; k >= 1; k--) begin
         if (n >= k) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
               if (hist[n-k+j] != pat[j]) ok = 1'b0;
            if (ok) return k;
         end
      end
      return 0;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_matches = 0;
      m_detect  = 1'b0;
   endtask

   task automatic model_edge(input bit b, input bit v, input bit c, input bit r);
      if (!r || c) begin
         model_reset();
      end else if (v) begin
         hist.push_back(b);
         if (hist.size() > 4) void'(hist.pop_front());
         m_detect = (exp_state() == 4);
         if (m_detect) m_matches++;
      end else begin
         m_detect = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state_a"},  32'(state_a),  32'(exp_state()));
      check({tag, ".detect_a"}, 32'(detect_a), 32'(m_detect));
      check({tag, ".count_a"},  32'(count_a),  32'(sat(m_matches, 255)));
      check({tag, ".state_b"},  32'(state_b),  32'(exp_state()));
      check({tag, ".detect_b"}, 32'(detect_b), 32'(m_detect));
      check({tag, ".count_b"},  32'(count_b),  32'(sat(m_matches, 3)));
   endtask

   // Drive one edge's inputs, let the edge happen, then compare 1ns later.
   task automatic step(input string tag, input bit b, input bit v, input bit c);
      bit_in    = b;
      bit_valid = v;
      clear     = c;
      @(posedge clk);
      model_edge(b, v, c, rst_n);
      #1;
      check_all(tag);
   endtask

   task automatic send(input string tag, input bit b);
      step(tag, b, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      clear     = 1'b0;
      model_reset();
      #2;
      check_all("reset_pre_edge");
      step("reset_held", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single match, then one idle edge so the pulse is seen to drop.
      send("m1_b0", 1'b1);
      send("m1_b1", 1'b0);
      send("m1_b2", 1'b1);
      send("m1_b3", 1'b1);
      check("m1_detect", 32'(detect_a), 32'd1);
      check("m1_count",  32'(count_a),  32'd1);
      check("m1_state",  32'(state_a),  32'd4);
      step("m1_idle", 1'b0, 1'b0, 1'b0);

      // Overlapping stream 1011011.
      step("ov_clr", 1'b0, 1'b0, 1'b1);
      foreach (pat[i]) send("ov_a", pat[i]);
      send("ov_b0", 1'b0);
      send("ov_b1", 1'b1);
      send("ov_b2", 1'b1);
      check("ov_count", 32'(count_a), 32'd2);

      // Gap of invalid bits holds state at 3.
      step("gap_clr", 1'b0, 1'b0, 1'b1);
      send("gap_b0", 1'b1);
      send("gap_b1", 1'b0);
      send("gap_b2", 1'b1);
      for (int i = 0; i < 3; i++) begin
         step("gap_idle", 1'(i % 2 == 0), 1'b0, 1'b0);
         check("gap_hold", 32'(state_a), 32'd3);
      end
      send("gap_b3", 1'b1);
      check("gap_count", 32'(count_a), 32'd1);

      // Five overlapping matches: narrow counter reads 1,2,3,3,3.
      step("sat_clr", 1'b0, 1'b0, 1'b1);
      foreach (pat[i]) send("sat_first", pat[i]);
      for (int m = 0; m < 4; m++) begin
         send("sat_b0", 1'b0);
         send("sat_b1", 1'b1);
         send("sat_b2", 1'b1);
      end
      check("sat_count_b", 32'(count_b), 32'd3);
      check("sat_count_a", 32'(count_a), 32'd5);

      // Clear on the completing edge wins.
      step("cc_clr", 1'b0, 1'b0, 1'b1);
      send("cc_b0", 1'b1);
      send("cc_b1", 1'b0);
      send("cc_b2", 1'b1);
      step("cc_hit", 1'b1, 1'b1, 1'b1);
      check("cc_detect", 32'(detect_a), 32'd0);
      check("cc_count",  32'(count_a),  32'd0);

      // Async reset mid-pattern between edges.
      send("ar_b0", 1'b1);
      send("ar_b1", 1'b0);
      send("ar_b2", 1'b1);
      send("ar_b3", 1'b1);
      send("ar_b4", 1'b0);
      send("ar_b5", 1'b1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("ar_async");
      check("ar_state0", 32'(state_a), 32'd0);
      step("ar_held", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send("ar_after0", 1'b1);
      send("ar_after1", 1'b1);
      check("ar_no_detect", 32'(detect_a), 32'd0);
      check("ar_state1",    32'(state_a),  32'd1);

      // Randomized stream with occasional clears.
      for (int i = 0; i < 400; i++) begin
         step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
